// File: rtl/sync_fwft_fifo.sv
// Single-clock first-word-fall-through FIFO; the head word is always visible on data_out.
// Optional sticky overflow/underflow flags are added when FIFO_ERR_FLAGS_EN is defined.
module sync_fwft_fifo #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  w_enable,
    input  logic                  r_enable,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full,
`ifdef FIFO_ERR_FLAGS_EN
    output logic                  overflow,
    output logic                  underflow,
`endif
    output logic                  empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]         r_wptr;
    logic [PW-1:0]         r_rptr;
    logic [CW-1:0]         r_cnt;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_we;
    logic                  w_re;
    logic [PW-1:0]         w_wptr_nxt;
    logic [PW-1:0]         w_rptr_nxt;

    // Flags decode registered occupancy only, so they never depend on same-cycle enables.
    assign w_full  = (r_cnt == CNT_FULL);
    assign w_empty = (r_cnt == '0);
    assign w_we    = w_enable && !w_full;
    assign w_re    = r_enable && !w_empty;

    // Explicit wrap keeps non-power-of-two depths correct.
    assign w_wptr_nxt = (r_wptr == PTR_LAST) ? '0 : r_wptr + 1'b1;
    assign w_rptr_nxt = (r_rptr == PTR_LAST) ? '0 : r_rptr + 1'b1;

    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[r_wptr] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_we) begin
                r_wptr <= w_wptr_nxt;
            end
            if (w_re) begin
                r_rptr <= w_rptr_nxt;
            end
            if (w_we && !w_re) begin
                r_cnt <= r_cnt + 1'b1;
            end else if (w_re && !w_we) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    assign full     = w_full;
    assign empty    = w_empty;
    assign data_out = w_empty ? '0 : r_mem[r_rptr];

`ifdef FIFO_ERR_FLAGS_EN
    logic r_overflow;
    logic r_underflow;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_enable && w_full) begin
                r_overflow <= 1'b1;
            end
            if (r_enable && w_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign overflow  = r_overflow;
    assign underflow = r_underflow;
`endif

endmodule

// File: tb/tb_sync_fwft_fifo.sv
// Directed bench for sync_fwft_fifo: a DEPTH=4 instance for the main plan and
// a DEPTH=3 instance to exercise non-power-of-two pointer wrap.
module tb_sync_fwft_fifo;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          w_enable, r_enable;
    logic [DW-1:0] data_in, data_out;
    logic          full, empty;
    logic          w3, r3;
    logic [DW-1:0] d3_in, d3_out;
    logic          full3, empty3;
`ifdef FIFO_ERR_FLAGS_EN
    logic          overflow, underflow, ovf3, udf3;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sync_fwft_fifo #(.DATA_WIDTH(DW), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .w_enable(w_enable), .r_enable(r_enable),
        .data_in(data_in), .data_out(data_out), .full(full),
`ifdef FIFO_ERR_FLAGS_EN
        .overflow(overflow), .underflow(underflow),
`endif
        .empty(empty)
    );

    sync_fwft_fifo #(.DATA_WIDTH(DW), .DEPTH(3)) dut3 (
        .clk(clk), .rst(rst), .w_enable(w3), .r_enable(r3),
        .data_in(d3_in), .data_out(d3_out), .full(full3),
`ifdef FIFO_ERR_FLAGS_EN
        .overflow(ovf3), .underflow(udf3),
`endif
        .empty(empty3)
    );

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic w, input logic r, input logic [DW-1:0] d);
        w_enable = w;
        r_enable = r;
        data_in  = d;
        step();
        w_enable = 1'b0;
        r_enable = 1'b0;
    endtask

    logic [DW-1:0] q[$];
    logic [DW-1:0] got[$];
    int            nxt;
    int            cyc;
    logic          wr, rd;
    int            sz;

    initial begin
        rst = 1'b1; w_enable = 1'b0; r_enable = 1'b0; data_in = '0;
        w3 = 1'b0; r3 = 1'b0; d3_in = '0;
        #1;
        step(); step();
        rst = 1'b0;
        chk("rst_empty", {15'd0, empty}, 16'd1);
        chk("rst_full",  {15'd0, full},  16'd0);
        chk("rst_dout",  data_out,       16'd0);

        drive(1'b0, 1'b1, 16'h0);
        chk("idle_pop_empty", {15'd0, empty}, 16'd1);
        chk("idle_pop_dout",  data_out,       16'd0);
`ifdef FIFO_ERR_FLAGS_EN
        chk("underflow_set", {15'd0, underflow}, 16'd1);
`endif

        drive(1'b1, 1'b0, 16'h5);
        chk("single_empty", {15'd0, empty}, 16'd0);
        chk("single_dout",  data_out,       16'h5);
        drive(1'b0, 1'b1, 16'h0);
        chk("single_pop_empty", {15'd0, empty}, 16'd1);
        chk("single_pop_dout",  data_out,       16'd0);

        for (int k = 1; k <= 5; k++) begin
            drive(1'b1, 1'b0, DW'(k));
            chk("fill_full", {15'd0, full}, (k >= 4) ? 16'd1 : 16'd0);
            chk("fill_head", data_out, 16'd1);
        end
`ifdef FIFO_ERR_FLAGS_EN
        chk("overflow_set", {15'd0, overflow}, 16'd1);
`endif
        for (int k = 1; k <= 4; k++) begin
            chk("drain_dout", data_out, DW'(k));
            drive(1'b0, 1'b1, 16'h0);
        end
        chk("drain_empty", {15'd0, empty}, 16'd1);
        chk("drain_dout0", data_out,       16'd0);

        drive(1'b1, 1'b0, 16'd10);
        drive(1'b1, 1'b0, 16'd11);
        drive(1'b1, 1'b1, 16'd12);
        chk("pp_dout",  data_out,       16'd11);
        chk("pp_full",  {15'd0, full},  16'd0);
        chk("pp_empty", {15'd0, empty}, 16'd0);
        drive(1'b0, 1'b1, 16'h0);
        chk("pp_next", data_out, 16'd12);
        drive(1'b0, 1'b1, 16'h0);
        chk("pp_drained", {15'd0, empty}, 16'd1);

        // Simultaneous push+pop when empty: write lands, read ignored.
        drive(1'b1, 1'b1, 16'h77);
        chk("pp_empty_dout", data_out, 16'h77);
        drive(1'b0, 1'b1, 16'h0);

        for (int k = 1; k <= 4; k++) drive(1'b1, 1'b0, DW'(k));
        chk("fpp_full_pre", {15'd0, full}, 16'd1);
        drive(1'b1, 1'b1, 16'd9);
        chk("fpp_full", {15'd0, full}, 16'd0);
        chk("fpp_dout", data_out,      16'd2);
        drive(1'b0, 1'b1, 16'h0);
        chk("fpp_3", data_out, 16'd3);
        drive(1'b0, 1'b1, 16'h0);
        chk("fpp_4", data_out, 16'd4);
        drive(1'b0, 1'b1, 16'h0);
        chk("fpp_empty", {15'd0, empty}, 16'd1);

        // Random stream of 0..19 against a queue model.
        q.delete(); got.delete(); nxt = 0; cyc = 0;
        while (got.size() < 20 && cyc < 2000) begin
            wr = ($urandom_range(0, 1) == 1) && (nxt < 20);
            rd = ($urandom_range(0, 2) != 0);
            sz = q.size();
            chk("rnd_empty", {15'd0, empty}, (sz == 0) ? 16'd1 : 16'd0);
            chk("rnd_full",  {15'd0, full},  (sz == 4) ? 16'd1 : 16'd0);
            chk("rnd_dout",  data_out,       (sz == 0) ? 16'd0 : q[0]);
            if (rd && sz > 0) got.push_back(q.pop_front());
            if (wr && sz < 4) begin
                q.push_back(DW'(nxt));
                nxt++;
            end
            drive(wr, rd, DW'(nxt - ((wr && sz < 4) ? 1 : 0)));
            cyc++;
        end
        chk("rnd_done", DW'(got.size()), 16'd20);
        for (int i = 0; i < got.size(); i++) chk("rnd_order", got[i], DW'(i));

        for (int k = 0; k < 3; k++) drive(1'b1, 1'b0, DW'(16'h30 + k));
        chk("pre_rst_head", data_out, (q.size() == 0) ? 16'h30 : q[0]);
        rst = 1'b1;
        drive(1'b1, 1'b1, 16'h99);
        rst = 1'b0;
        chk("mid_rst_empty", {15'd0, empty}, 16'd1);
        chk("mid_rst_full",  {15'd0, full},  16'd0);
        chk("mid_rst_dout",  data_out,       16'd0);
`ifdef FIFO_ERR_FLAGS_EN
        chk("rst_ovf_clr", {15'd0, overflow},  16'd0);
        chk("rst_udf_clr", {15'd0, underflow}, 16'd0);
`endif
        drive(1'b1, 1'b0, 16'h42);
        chk("post_rst_dout", data_out, 16'h42);

        // DEPTH=3: four fill/drain rounds so both pointers wrap repeatedly.
        for (int rnd = 0; rnd < 4; rnd++) begin
            for (int i = 0; i < 4; i++) begin
                w3 = 1'b1; d3_in = DW'(rnd * 8 + i);
                step();
            end
            w3 = 1'b0;
            chk("d3_full", {15'd0, full3}, 16'd1);
            for (int i = 0; i < 3; i++) begin
                chk("d3_dout", d3_out, DW'(rnd * 8 + i));
                r3 = 1'b1;
                step();
            end
            r3 = 1'b0;
            chk("d3_empty", {15'd0, empty3}, 16'd1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sync_fwft_fifo.md
Name: sync_fwft_fifo

Overview:
- Single-clock, first-word-fall-through (FWFT) FIFO used as the ingress buffer of the RTL-add client and other streaming blocks.
- Head-of-queue word is always presented combinationally on data_out.
- A read acknowledges (pops) that word. Status flags drive ready/valid handshakes directly: ready = ~full, valid = ~empty.

Parameters:
- DATA_WIDTH, 64, width of each stored word in bits (>=1).
- DEPTH, 16, number of storage entries (>=2; non-power-of-two supported).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- w_enable  input  1  push request; data_in written when w_enable && !full.
- r_enable  input  1  pop request; head discarded when r_enable && !empty.
- data_in  input  DATA_WIDTH  word to push.
- data_out  output  DATA_WIDTH  current head word (FWFT); all-zero when empty.
- full  output  1  high when occupancy == DEPTH.
- empty  output  1  high when occupancy == 0.

Behaviour:
- State consists of:
  - storage array of DEPTH words;
  - write pointer and read pointer, each 0..DEPTH-1;
  - occupancy counter, 0..DEPTH, width clog2(DEPTH+1).
- Reset (rst=1 at posedge): pointers and occupancy go to 0, so empty=1, full=0, data_out=0. Storage contents are not cleared.
- Reset mid-operation discards all stored words; the next cycle behaves as freshly reset. rst has priority over w_enable and r_enable.
- Effective write is we = w_enable && !full. On we, mem[wptr] <= data_in and wptr advances.
- Effective read is re = r_enable && !empty. On re, rptr advances.
- Pointer wrap: pointer == DEPTH-1 advances to 0. No power-of-two assumption.
- Occupancy update:
  - +1 on we && !re;
  - -1 on re && !we;
  - unchanged on both or neither.
- full and empty are combinational decodes of the registered occupancy (no dependence on same-cycle enables).
- data_out = mem[rptr] when !empty, else 0. It is purely combinational from registered state.
- Latency: a word written at edge N appears on data_out after edge N if the FIFO was empty. There is no same-cycle write-to-read bypass.
- Simultaneous push+pop:
  - When 0 < occupancy < DEPTH: both take effect; occupancy unchanged; ordering preserved.
  - When full: the read occurs, the write is dropped (full gates we); occupancy becomes DEPTH-1.
  - When empty: the write occurs, the read is ignored; occupancy becomes 1.
- Push while full is ignored: no state change, data_in lost.
- Pop while empty is ignored: no state change.
- Order strictly first-in first-out across any number of wraps.

Optional Feature:
- Macro FIFO_ERR_FLAGS_EN.
- When defined, adds two outputs:
  - overflow: 1 bit, sticky; set at posedge when w_enable && full.
  - underflow: 1 bit, sticky; set at posedge when r_enable && empty.
- Both flags clear only on rst and do not alter data-path behaviour.
- When undefined, the ports and logic are absent, and the attempts are silently ignored as above.

Test Plan:
- Reset then idle: assert rst 2 cycles, release -> empty=1, full=0, data_out=0; r_enable=1 with empty causes no change.
- Single word: push 0x5 one cycle -> next cycle empty=0, data_out=0x5; pop -> next cycle empty=1, data_out=0.
- Fill/overflow (DEPTH=4): push 1,2,3,4,5 on consecutive cycles -> full=1 after 4th push, 5 dropped; pops return 1,2,3,4 then empty=1; with FIFO_ERR_FLAGS_EN, overflow=1.
- Simultaneous push/pop: hold occupancy 2 (10,11); push 12 + pop same cycle -> data_out=11, occupancy 2; continue to read 11,12 in order.
- Full with push+pop (DEPTH=4, full of 1..4): w_enable=r_enable=1 with data_in=9 -> 1 popped, 9 dropped, full=0, next reads 2,3,4.
- Wrap and reset: stream 20 words (0..19) through DEPTH=4 with random push/pop -> output order 0..19 exact; assert rst with 3 words stored -> next cycle empty=1, data_out=0.
